// File: rtl/axi4_dma_pkg.sv
// Shared types and constants for the AXI4 multi-outstanding read DMA.
package axi4_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  // AXI arsize encoding for a bus of data_w bits (log2 of bytes per beat).
  function automatic logic [2:0] size_of(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi4_dma_ar_gen.sv
// AR request generator: address accumulator, issued-burst counter and the
// valid/ready hold. Addresses advance by a fixed byte increment per
// accepted burst (accumulated, never multiplied) and wrap modulo 2^ADDR_W.
module axi4_dma_ar_gen
  import axi4_dma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] incr_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic              en_i,
  input  logic              arready_i,
  output logic              arvalid_o,
  output logic [ADDR_W-1:0] araddr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] incr_q;
  logic [CNT_W-1:0]  issued_q;

  // en_i only falls on an AR handshake or on reset, so a pending request
  // is never withdrawn while the slave stalls.
  assign arvalid_o = en_i && (issued_q < num_i);
  assign araddr_o  = addr_q;

  // Address/issue bookkeeping: reload on start, advance on each AR handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      incr_q   <= '0;
      issued_q <= '0;
    end else if (load_i) begin
      addr_q   <= start_addr_i;
      incr_q   <= incr_i;
      issued_q <= '0;
    end else if (arvalid_o && arready_i) begin
      addr_q   <= addr_q + incr_q;
      issued_q <= issued_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi4_dma_read_mo.sv
// AXI4 read DMA with up to MAX_OUTST bursts in flight, ap_* control plane
// and a zero-latency valid/ready output stream.
// Optional feature macro DMA_RRESP_CHECK_EN: sticky io_err on non-OKAY rresp.
//
// state | meaning
// IDLE  | waiting for io_ap_start, io_ap_idle high
// RUN   | issuing AR bursts and forwarding R beats
// DONE  | one-cycle ap_done/ap_ready pulse, then back to IDLE
module axi4_dma_read_mo
  import axi4_dma_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 1,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_axi_arvalid,
  input  logic              io_axi_arready,
  output logic [ADDR_W-1:0] io_axi_araddr,
  output logic [ID_W-1:0]   io_axi_arid,
  output logic [7:0]        io_axi_arlen,
  output logic [2:0]        io_axi_arsize,
  output logic [1:0]        io_axi_arburst,
  input  logic              io_axi_rvalid,
  output logic              io_axi_rready,
  input  logic [DATA_W-1:0] io_axi_rdata,
  input  logic [ID_W-1:0]   io_axi_rid,
  input  logic [1:0]        io_axi_rresp,
  input  logic              io_axi_rlast,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_last,
  input  logic [ADDR_W-1:0] io_start_addr,
  input  logic [7:0]        io_len_burst,
  input  logic [CNT_W-1:0]  io_num_burst,
  input  logic [15:0]       io_stride,
  output logic [CNT_W-1:0]  io_cnt_clk,
  output logic              io_err,
  input  logic              io_ap_start,
  output logic              io_ap_ready,
  output logic              io_ap_done,
  output logic              io_ap_idle
);

  localparam logic [2:0] AR_SIZE = size_of(DATA_W);
  localparam int         OUT_W   = $clog2(MAX_OUTST + 1);

  dma_state_t         state_q;
  logic               ap_idle_q;
  logic               ap_done_q;
  logic [7:0]         len_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   rx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   outst_q;

  logic               run;
  logic               load;
  logic               ar_en;
  logic               ar_hs;
  logic               r_hs;
  logic               rlast_hs;
  logic [15:0]        stride_eff;
  logic [ADDR_W-1:0]  incr;

  logic               unused_rid;
  assign unused_rid = ^io_axi_rid;

  assign run  = (state_q == RUN);
  assign load = (state_q == IDLE) && io_ap_start;

  // Stride 0 means back-to-back bursts; increment is in bytes.
  assign stride_eff = (io_stride == 16'd0) ? (16'(io_len_burst) + 16'd1) : io_stride;
  assign incr       = ADDR_W'(stride_eff) << AR_SIZE;

  assign ar_en    = run && (outst_q < OUT_W'(MAX_OUTST));
  assign ar_hs    = io_axi_arvalid && io_axi_arready;
  assign r_hs     = io_axi_rvalid && io_axi_rready;
  assign rlast_hs = r_hs && io_axi_rlast;

  assign io_axi_arid    = '0;
  assign io_axi_arlen   = len_q;
  assign io_axi_arsize  = AR_SIZE;
  assign io_axi_arburst = AXI_BURST_INCR;

  assign io_axi_rready = run && io_out_ready;
  assign io_out_valid  = run && io_axi_rvalid;
  assign io_out_data   = io_axi_rdata;
  assign io_out_last   = run && io_axi_rlast && (rx_q == num_q - CNT_W'(1));

  assign io_cnt_clk  = cnt_q;
  assign io_ap_idle  = ap_idle_q;
  assign io_ap_done  = ap_done_q;
  assign io_ap_ready = ap_done_q;

  axi4_dma_ar_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_ar_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .start_addr_i (io_start_addr),
    .incr_i       (incr),
    .num_i        (num_q),
    .en_i         (ar_en),
    .arready_i    (io_axi_arready),
    .arvalid_o    (io_axi_arvalid),
    .araddr_o     (io_axi_araddr)
  );

  // Control FSM with registered ap_idle/ap_done; latches the job on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ap_idle_q <= 1'b1;
      ap_done_q <= 1'b0;
      len_q     <= '0;
      num_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_ap_start) begin
            len_q     <= io_len_burst;
            num_q     <= io_num_burst;
            ap_idle_q <= 1'b0;
            if (io_num_burst == '0) begin
              state_q   <= DONE;
              ap_done_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (rx_q == num_q) begin
            state_q   <= DONE;
            ap_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          ap_done_q <= 1'b0;
          ap_idle_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          ap_done_q <= 1'b0;
          ap_idle_q <= 1'b1;
        end
      endcase
    end
  end

  // Bursts accepted on AR but not yet closed by an accepted rlast.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      outst_q <= '0;
    end else begin
      case ({ar_hs, rlast_hs})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Completed-burst counter; drives completion and the final-beat marker.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      rx_q <= '0;
    end else if (rlast_hs) begin
      rx_q <= rx_q + CNT_W'(1);
    end
  end

  // Saturating count of RUN cycles, held until the next start.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef DMA_RRESP_CHECK_EN
  logic err_q;
  assign io_err = err_q;

  // Sticky error flag on any non-OKAY beat; data keeps flowing regardless.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      err_q <= 1'b0;
    end else if (r_hs && (io_axi_rresp != AXI_RESP_OKAY)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^io_axi_rresp;
  assign io_err       = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_dma_read_mo.sv
// Directed testbench for axi4_dma_read_mo with a simple AXI read slave model.
module tb_axi4_dma_read_mo;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 1;
  localparam int CNT_W  = 32;
  localparam int MAXC   = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_axi_arvalid;
  logic              io_axi_arready;
  logic [ADDR_W-1:0] io_axi_araddr;
  logic [ID_W-1:0]   io_axi_arid;
  logic [7:0]        io_axi_arlen;
  logic [2:0]        io_axi_arsize;
  logic [1:0]        io_axi_arburst;
  logic              io_axi_rvalid;
  logic              io_axi_rready;
  logic [DATA_W-1:0] io_axi_rdata;
  logic [ID_W-1:0]   io_axi_rid;
  logic [1:0]        io_axi_rresp;
  logic              io_axi_rlast;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;
  logic [ADDR_W-1:0] io_start_addr;
  logic [7:0]        io_len_burst;
  logic [CNT_W-1:0]  io_num_burst;
  logic [15:0]       io_stride;
  logic [CNT_W-1:0]  io_cnt_clk;
  logic              io_err;
  logic              io_ap_start;
  logic              io_ap_ready;
  logic              io_ap_done;
  logic              io_ap_idle;

  int n_checks = 0;
  int n_fail   = 0;

  // Results collected by run_xfer for the test tasks to judge.
  logic [ADDR_W-1:0] ar_addrs[$];
  logic [DATA_W-1:0] beat_data[$];
  bit                beat_last[$];
  int                arlen_bad, stall_viol, max_outst, done_cyc, done_cnt, run_cyc, ar_at_hold;
  bit                arvalid_at_hold, timed_out, ready_bad, idle_after, err_end;
  logic [CNT_W-1:0]  cnt_end;

  always #5 clk = ~clk;

  axi4_dma_read_mo dut (
    .clk            (clk),
    .reset          (reset),
    .io_axi_arvalid (io_axi_arvalid),
    .io_axi_arready (io_axi_arready),
    .io_axi_araddr  (io_axi_araddr),
    .io_axi_arid    (io_axi_arid),
    .io_axi_arlen   (io_axi_arlen),
    .io_axi_arsize  (io_axi_arsize),
    .io_axi_arburst (io_axi_arburst),
    .io_axi_rvalid  (io_axi_rvalid),
    .io_axi_rready  (io_axi_rready),
    .io_axi_rdata   (io_axi_rdata),
    .io_axi_rid     (io_axi_rid),
    .io_axi_rresp   (io_axi_rresp),
    .io_axi_rlast   (io_axi_rlast),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_data    (io_out_data),
    .io_out_last    (io_out_last),
    .io_start_addr  (io_start_addr),
    .io_len_burst   (io_len_burst),
    .io_num_burst   (io_num_burst),
    .io_stride      (io_stride),
    .io_cnt_clk     (io_cnt_clk),
    .io_err         (io_err),
    .io_ap_start    (io_ap_start),
    .io_ap_ready    (io_ap_ready),
    .io_ap_done     (io_ap_done),
    .io_ap_idle     (io_ap_idle)
  );

  // Runs one job against the slave model. Inputs change at negedge, outputs
  // are sampled 1 time unit later. abort_at>0 returns early at that cycle.
  task automatic run_xfer(input logic [ADDR_W-1:0] sa, input logic [7:0] len,
                          input logic [CNT_W-1:0] num, input logic [15:0] stride,
                          input bit rnd_ar, input bit rnd_out, input int rhold,
                          input int bad_beat, input int abort_at);
    logic [ADDR_W-1:0] mq[$];
    logic [ADDR_W-1:0] prev_addr;
    int  beat_j = 0;
    int  outst = 0;
    int  gbeat = 0;
    bit  prev_stall = 0;
    bit  finished = 0;
    ar_addrs.delete(); beat_data.delete(); beat_last.delete();
    arlen_bad = 0; stall_viol = 0; max_outst = 0; done_cyc = -1; done_cnt = 0;
    run_cyc = 0; ar_at_hold = -1; arvalid_at_hold = 1'b0; timed_out = 1'b0;
    ready_bad = 1'b0; idle_after = 1'b0; err_end = 1'b0; cnt_end = '0;
    prev_addr = '0;
    @(negedge clk);
    io_start_addr = sa; io_len_burst = len; io_num_burst = num; io_stride = stride;
    io_ap_start = 1'b1; io_axi_arready = 1'b0; io_axi_rvalid = 1'b0;
    io_axi_rlast = 1'b0; io_axi_rresp = 2'b00; io_out_ready = 1'b0;
    for (int cyc = 1; cyc <= MAXC; cyc++) begin
      @(negedge clk);
      io_ap_start = 1'b0;
      if (abort_at != 0 && cyc == abort_at) return;
      io_axi_arready = rnd_ar  ? 1'($urandom_range(0, 1)) : 1'b1;
      io_out_ready   = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mq.size() > 0 && cyc > rhold) begin
        io_axi_rvalid = 1'b1;
        io_axi_rdata  = DATA_W'(mq[0] + 64'(beat_j * 64));
        io_axi_rlast  = (beat_j == int'(len));
        io_axi_rresp  = (gbeat == bad_beat) ? 2'b10 : 2'b00;
      end else begin
        io_axi_rvalid = 1'b0;
        io_axi_rdata  = '0;
        io_axi_rlast  = 1'b0;
        io_axi_rresp  = 2'b00;
      end
      #1;
      if (cyc == rhold) begin
        ar_at_hold      = ar_addrs.size();
        arvalid_at_hold = io_axi_arvalid;
      end
      if (prev_stall && (io_axi_arvalid !== 1'b1 || io_axi_araddr !== prev_addr)) stall_viol++;
      prev_stall = io_axi_arvalid && !io_axi_arready;
      prev_addr  = io_axi_araddr;
      if (io_axi_arvalid && io_axi_arready) begin
        ar_addrs.push_back(io_axi_araddr);
        mq.push_back(io_axi_araddr);
        if (io_axi_arlen !== len) arlen_bad++;
        outst++;
      end
      if (io_axi_rvalid && io_axi_rready) begin
        if (io_out_valid) begin
          beat_data.push_back(io_out_data);
          beat_last.push_back(io_out_last);
        end
        gbeat++;
        if (io_axi_rlast) begin
          void'(mq.pop_front());
          beat_j = 0;
          outst--;
        end else begin
          beat_j++;
        end
      end
      if (outst > max_outst) max_outst = outst;
      if (!io_ap_idle && !io_ap_done) run_cyc++;
      if (io_ap_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!io_ap_ready) ready_bad = 1'b1;
        cnt_end = io_cnt_clk;
        err_end = io_err;
      end else if (done_cnt > 0) begin
        idle_after = io_ap_idle;
        finished = 1'b1;
        break;
      end
    end
    if (!finished) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++; if (io_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", io_axi_arvalid); end
    n_checks++; if (io_axi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %b exp 0", io_axi_rready); end
    n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", io_out_valid); end
    n_checks++; if (io_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", io_out_last); end
    n_checks++; if (io_ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_ap_idle got %b exp 1", io_ap_idle); end
    n_checks++; if (io_ap_done !== 1'b0 || io_ap_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ap_done got %b/%b exp 0/0", io_ap_done, io_ap_ready); end
    n_checks++; if (io_cnt_clk !== '0) begin n_fail++; $display("FAIL reset_cnt_clk got %0d exp 0", io_cnt_clk); end
    n_checks++; if (io_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", io_err); end
    n_checks++; if (io_axi_araddr !== '0 || io_axi_arlen !== 8'd0) begin n_fail++; $display("FAIL reset_araddr got %h/%0d exp 0/0", io_axi_araddr, io_axi_arlen); end
    n_checks++; if (io_axi_arsize !== 3'd6 || io_axi_arburst !== 2'b01 || io_axi_arid !== '0) begin n_fail++; $display("FAIL reset_arconst got %0d/%0d/%0d exp 6/1/0", io_axi_arsize, io_axi_arburst, io_axi_arid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [ADDR_W-1:0] exp_a;
    run_xfer(64'h1000, 8'd3, 32'd4, 16'd0, 1'b0, 1'b0, 0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got timeout exp done"); end
    n_checks++; if (ar_addrs.size() != 4) begin n_fail++; $display("FAIL basic_ar_count got %0d exp 4", ar_addrs.size()); end
    for (int i = 0; i < ar_addrs.size() && i < 4; i++) begin
      exp_a = 64'h1000 + 64'(i * 'h100);
      n_checks++; if (ar_addrs[i] !== exp_a) begin n_fail++; $display("FAIL basic_araddr[%0d] got %h exp %h", i, ar_addrs[i], exp_a); end
    end
    n_checks++; if (arlen_bad != 0) begin n_fail++; $display("FAIL basic_arlen got %0d bad exp 0", arlen_bad); end
    n_checks++; if (beat_data.size() != 16) begin n_fail++; $display("FAIL basic_beats got %0d exp 16", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 16; i++) begin
      exp_a = 64'h1000 + 64'((i / 4) * 'h100) + 64'((i % 4) * 64);
      n_checks++; if (beat_data[i] !== DATA_W'(exp_a)) begin n_fail++; $display("FAIL basic_data[%0d] got %h exp %h", i, beat_data[i][63:0], exp_a); end
      n_checks++; if (beat_last[i] !== (i == 15)) begin n_fail++; $display("FAIL basic_last[%0d] got %b exp %b", i, beat_last[i], (i == 15)); end
    end
    n_checks++; if (done_cnt != 1 || done_cyc != 19) begin n_fail++; $display("FAIL basic_done got cnt %0d cyc %0d exp 1/19", done_cnt, done_cyc); end
    n_checks++; if (ready_bad) begin n_fail++; $display("FAIL basic_ap_ready got 0 with done exp 1"); end
    n_checks++; if (cnt_end !== 32'd18) begin n_fail++; $display("FAIL basic_cnt_clk got %0d exp 18", cnt_end); end
    n_checks++; if (!idle_after) begin n_fail++; $display("FAIL basic_idle_after got 0 exp 1"); end
    n_checks++; if (max_outst != 4) begin n_fail++; $display("FAIL basic_max_outst got %0d exp 4", max_outst); end
  endtask

  task automatic test_outstanding();
    run_xfer(64'h2000, 8'd3, 32'd8, 16'd0, 1'b0, 1'b0, 50, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL outst_timeout got timeout exp done"); end
    n_checks++; if (ar_at_hold != 4) begin n_fail++; $display("FAIL outst_ar_during_hold got %0d exp 4", ar_at_hold); end
    n_checks++; if (arvalid_at_hold !== 1'b0) begin n_fail++; $display("FAIL outst_arvalid_hold got %b exp 0", arvalid_at_hold); end
    n_checks++; if (max_outst != 4) begin n_fail++; $display("FAIL outst_max got %0d exp 4", max_outst); end
    n_checks++; if (ar_addrs.size() != 8) begin n_fail++; $display("FAIL outst_ar_total got %0d exp 8", ar_addrs.size()); end
    n_checks++; if (beat_data.size() != 32) begin n_fail++; $display("FAIL outst_beats got %0d exp 32", beat_data.size()); end
    n_checks++; if (beat_data.size() == 32 && beat_data[31] !== DATA_W'(64'h2000 + 64'h700 + 64'hC0)) begin n_fail++; $display("FAIL outst_last_data got %h exp %h", beat_data[31][63:0], 64'h27C0); end
    n_checks++; if (cnt_end !== 32'(run_cyc)) begin n_fail++; $display("FAIL outst_cnt_clk got %0d exp %0d", cnt_end, run_cyc); end
  endtask

  task automatic test_stride();
    logic [ADDR_W-1:0] exp_a;
    run_xfer(64'h0, 8'd1, 32'd3, 16'd8, 1'b0, 1'b0, 0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stride_timeout got timeout exp done"); end
    n_checks++; if (ar_addrs.size() != 3) begin n_fail++; $display("FAIL stride_ar_count got %0d exp 3", ar_addrs.size()); end
    for (int i = 0; i < ar_addrs.size() && i < 3; i++) begin
      exp_a = 64'(i * 'h200);
      n_checks++; if (ar_addrs[i] !== exp_a) begin n_fail++; $display("FAIL stride_araddr[%0d] got %h exp %h", i, ar_addrs[i], exp_a); end
    end
    n_checks++; if (beat_data.size() != 6) begin n_fail++; $display("FAIL stride_beats got %0d exp 6", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 6; i++) begin
      exp_a = 64'((i / 2) * 'h200 + (i % 2) * 64);
      n_checks++; if (beat_data[i] !== DATA_W'(exp_a)) begin n_fail++; $display("FAIL stride_data[%0d] got %h exp %h", i, beat_data[i][63:0], exp_a); end
    end
  endtask

  task automatic test_zero();
    run_xfer(64'h4000, 8'd3, 32'd0, 16'd0, 1'b0, 1'b0, 0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL zero_timeout got timeout exp done"); end
    n_checks++; if (ar_addrs.size() != 0) begin n_fail++; $display("FAIL zero_ar_count got %0d exp 0", ar_addrs.size()); end
    n_checks++; if (done_cyc != 1 || done_cnt != 1) begin n_fail++; $display("FAIL zero_done got cyc %0d cnt %0d exp 1/1", done_cyc, done_cnt); end
    n_checks++; if (cnt_end !== '0) begin n_fail++; $display("FAIL zero_cnt_clk got %0d exp 0", cnt_end); end
    n_checks++; if (beat_data.size() != 0) begin n_fail++; $display("FAIL zero_beats got %0d exp 0", beat_data.size()); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] exp_a;
    run_xfer(64'h8000, 8'd2, 32'd5, 16'd4, 1'b1, 1'b1, 0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rand_timeout got timeout exp done"); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand_ar_stable got %0d violations exp 0", stall_viol); end
    n_checks++; if (ar_addrs.size() != 5) begin n_fail++; $display("FAIL rand_ar_count got %0d exp 5", ar_addrs.size()); end
    for (int i = 0; i < ar_addrs.size() && i < 5; i++) begin
      exp_a = 64'h8000 + 64'(i * 'h100);
      n_checks++; if (ar_addrs[i] !== exp_a) begin n_fail++; $display("FAIL rand_araddr[%0d] got %h exp %h", i, ar_addrs[i], exp_a); end
    end
    n_checks++; if (beat_data.size() != 15) begin n_fail++; $display("FAIL rand_beats got %0d exp 15", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 15; i++) begin
      exp_a = 64'h8000 + 64'((i / 3) * 'h100 + (i % 3) * 64);
      n_checks++; if (beat_data[i] !== DATA_W'(exp_a)) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", i, beat_data[i][63:0], exp_a); end
      n_checks++; if (beat_last[i] !== (i == 14)) begin n_fail++; $display("FAIL rand_last[%0d] got %b exp %b", i, beat_last[i], (i == 14)); end
    end
    n_checks++; if (cnt_end !== 32'(run_cyc)) begin n_fail++; $display("FAIL rand_cnt_clk got %0d exp %0d", cnt_end, run_cyc); end
    n_checks++; if (max_outst > 4) begin n_fail++; $display("FAIL rand_max_outst got %0d exp <=4", max_outst); end
  endtask

  task automatic test_rresp();
    bit exp_err;
`ifdef DMA_RRESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_xfer(64'h0, 8'd1, 32'd2, 16'd0, 1'b0, 1'b0, 0, 1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL rresp_timeout got timeout exp done"); end
    n_checks++; if (err_end !== exp_err) begin n_fail++; $display("FAIL rresp_err got %b exp %b", err_end, exp_err); end
    n_checks++; if (beat_data.size() != 4) begin n_fail++; $display("FAIL rresp_beats got %0d exp 4", beat_data.size()); end
    n_checks++; if (beat_data.size() == 4 && beat_data[1] !== DATA_W'(64'h40)) begin n_fail++; $display("FAIL rresp_bad_beat_data got %h exp 40", beat_data[1][63:0]); end
    n_checks++; if (io_err !== exp_err) begin n_fail++; $display("FAIL rresp_sticky got %b exp %b", io_err, exp_err); end
    run_xfer(64'h0, 8'd1, 32'd2, 16'd0, 1'b0, 1'b0, 0, -1, 0);
    n_checks++; if (err_end !== 1'b0) begin n_fail++; $display("FAIL rresp_clear got %b exp 0", err_end); end
  endtask

  task automatic test_reset_mid();
    run_xfer(64'h3000, 8'd3, 32'd8, 16'd0, 1'b0, 1'b0, 0, -1, 6);
    io_axi_rvalid = 1'b1; io_out_ready = 1'b1; io_axi_arready = 1'b1;
    io_axi_rlast = 1'b0; io_axi_rresp = 2'b00;
    #1;
    n_checks++; if (io_ap_idle !== 1'b0) begin n_fail++; $display("FAIL mid_busy_before got idle %b exp 0", io_ap_idle); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (io_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_arvalid got %b exp 0", io_axi_arvalid); end
    n_checks++; if (io_axi_rready !== 1'b0) begin n_fail++; $display("FAIL mid_rready got %b exp 0", io_axi_rready); end
    n_checks++; if (io_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b exp 0", io_out_valid); end
    n_checks++; if (io_ap_idle !== 1'b1) begin n_fail++; $display("FAIL mid_ap_idle got %b exp 1", io_ap_idle); end
    @(negedge clk);
    reset = 1'b0; io_axi_rvalid = 1'b0;
    run_xfer(64'h5000, 8'd0, 32'd2, 16'd0, 1'b0, 1'b0, 0, -1, 0);
    n_checks++; if (timed_out || done_cnt != 1) begin n_fail++; $display("FAIL mid_restart got done %0d exp 1", done_cnt); end
    n_checks++; if (ar_addrs.size() != 2 || ar_addrs[0] !== 64'h5000 || ar_addrs[1] !== 64'h5040) begin n_fail++; $display("FAIL mid_restart_addr got %0d addrs exp 5000/5040", ar_addrs.size()); end
  endtask

  initial begin
    reset = 1'b1;
    io_axi_arready = 1'b0; io_axi_rvalid = 1'b0; io_axi_rdata = '0; io_axi_rid = '0;
    io_axi_rresp = 2'b00; io_axi_rlast = 1'b0; io_out_ready = 1'b0;
    io_start_addr = '0; io_len_burst = '0; io_num_burst = '0; io_stride = '0;
    io_ap_start = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_outstanding();
    test_stride();
    test_zero();
    test_random();
    test_rresp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
